// File: rtl/multicycle_cpu_if.sv
// Memory-side bus of the multi-cycle core: instruction fetch port and data
// access port, each a req/valid handshake tolerant of any number of wait states.
interface multicycle_cpu_if #(
  parameter int A_WIDTH = 32,
  parameter int D_WIDTH = 32
);
  logic               imem_req;
  logic [A_WIDTH-1:0] imem_addr;
  logic [31:0]        imem_rdata;
  logic               imem_valid;
  logic               dmem_req;
  logic               dmem_we;
  logic [A_WIDTH-1:0] dmem_addr;
  logic [D_WIDTH-1:0] dmem_wdata;
  logic [D_WIDTH-1:0] dmem_rdata;
  logic               dmem_valid;

  modport master (
    output imem_req, imem_addr, dmem_req, dmem_we, dmem_addr, dmem_wdata,
    input  imem_rdata, imem_valid, dmem_rdata, dmem_valid
  );

  modport slave (
    input  imem_req, imem_addr, dmem_req, dmem_we, dmem_addr, dmem_wdata,
    output imem_rdata, imem_valid, dmem_rdata, dmem_valid
  );
endinterface

// File: rtl/multicycle_cpu.sv
// Multi-cycle RV32I-subset core (ADD/SUB/AND/OR/ADDI/LW/SW/BEQ/BNE).
// One shared ALU; an FSM sequences fetch/decode/execute/memory/writeback and
// waits on external memories. x10 is exported on a0; illegal code halts.
module multicycle_cpu #(
  parameter int                 D_WIDTH   = 32,
  parameter int                 A_WIDTH   = 32,
  parameter int                 REG_COUNT = 32,
  parameter logic [A_WIDTH-1:0] RESET_PC  = '0
) (
  input  logic               clk,
  input  logic               rst,
  multicycle_cpu_if.master   bus,
  output logic [D_WIDTH-1:0] a0,
  output logic               halted
);

  localparam int RIW = $clog2(REG_COUNT);

  typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT} state_t;
  typedef enum logic [2:0] {C_ALUR, C_ALUI, C_LOAD, C_STORE, C_BRANCH} cls_t;
  typedef enum logic [1:0] {OP_ADD, OP_SUB, OP_AND, OP_OR} aop_t;

  state_t state, state_n;
  cls_t   cls, dcls;
  aop_t   aop, dop, alu_op;

  logic [A_WIDTH-1:0]        pc, pc_plus4, br_off;
  logic [31:0]               ir;
  logic signed [D_WIDTH-1:0] rs1v, rs2v, imm, res;
  logic signed [D_WIDTH-1:0] dimm, rs1_rd, rs2_rd, alu_b, alu_y;
  logic [D_WIDTH-1:0]        regs [REG_COUNT];

  logic [6:0] opc, f7;
  logic [2:0] f3;
  logic [4:0] rd, rs1, rs2;
  logic       known, use_rd, use_rs1, use_rs2, dec_ok, taken;
  logic       ireq, dreq;

  // Sign-extend a 13-bit immediate (I/S formats pass their sign bit twice).
  function automatic logic signed [D_WIDTH-1:0] sext13(input logic [12:0] v);
    return {{(D_WIDTH-13){v[12]}}, v};
  endfunction

  // A register index is usable only if the configured file holds it.
  function automatic logic idx_ok(input logic [4:0] i);
    return int'(i) < REG_COUNT;
  endfunction

  assign opc = ir[6:0];
  assign rd  = ir[11:7];
  assign f3  = ir[14:12];
  assign rs1 = ir[19:15];
  assign rs2 = ir[24:20];
  assign f7  = ir[31:25];

  // Decode the latched instruction: class, ALU op, immediate, legality.
  always_comb begin
    known   = 1'b0;
    use_rd  = 1'b0;
    use_rs1 = 1'b0;
    use_rs2 = 1'b0;
    dcls    = C_ALUR;
    dop     = OP_ADD;
    dimm    = '0;
    case (opc)
      7'b0110011: begin
        dcls    = C_ALUR;
        use_rd  = 1'b1;
        use_rs1 = 1'b1;
        use_rs2 = 1'b1;
        case ({f7, f3})
          10'b0000000_000: begin known = 1'b1; dop = OP_ADD; end
          10'b0100000_000: begin known = 1'b1; dop = OP_SUB; end
          10'b0000000_111: begin known = 1'b1; dop = OP_AND; end
          10'b0000000_110: begin known = 1'b1; dop = OP_OR;  end
          default:         known = 1'b0;
        endcase
      end
      7'b0010011: begin
        dcls    = C_ALUI;
        use_rd  = 1'b1;
        use_rs1 = 1'b1;
        known   = (f3 == 3'b000);
        dimm    = sext13({ir[31], ir[31:20]});
      end
      7'b0000011: begin
        dcls    = C_LOAD;
        use_rd  = 1'b1;
        use_rs1 = 1'b1;
        known   = (f3 == 3'b010);
        dimm    = sext13({ir[31], ir[31:20]});
      end
      7'b0100011: begin
        dcls    = C_STORE;
        use_rs1 = 1'b1;
        use_rs2 = 1'b1;
        known   = (f3 == 3'b010);
        dimm    = sext13({ir[31], ir[31:25], ir[11:7]});
      end
      7'b1100011: begin
        dcls    = C_BRANCH;
        use_rs1 = 1'b1;
        use_rs2 = 1'b1;
        known   = (f3 == 3'b000) || (f3 == 3'b001);
        dimm    = sext13({ir[31], ir[7], ir[30:25], ir[11:8], 1'b0});
      end
      default: known = 1'b0;
    endcase
    dec_ok = known && (!use_rd || idx_ok(rd)) && (!use_rs1 || idx_ok(rs1)) &&
             (!use_rs2 || idx_ok(rs2));
  end

  // Register file read ports; x0 and out-of-range indices read as zero.
  always_comb begin
    rs1_rd = '0;
    rs2_rd = '0;
    if (rs1 != 5'd0 && idx_ok(rs1)) rs1_rd = regs[rs1[RIW-1:0]];
    if (rs2 != 5'd0 && idx_ok(rs2)) rs2_rd = regs[rs2[RIW-1:0]];
  end

  // Shared ALU: register ops, address generation and branch compare (via SUB).
  always_comb begin
    alu_b = (cls == C_ALUR || cls == C_BRANCH) ? rs2v : imm;
    case (cls)
      C_ALUR:   alu_op = aop;
      C_BRANCH: alu_op = OP_SUB;
      default:  alu_op = OP_ADD;
    endcase
    case (alu_op)
      OP_ADD:  alu_y = rs1v + alu_b;
      OP_SUB:  alu_y = rs1v - alu_b;
      OP_AND:  alu_y = rs1v & alu_b;
      OP_OR:   alu_y = rs1v | alu_b;
      default: alu_y = rs1v + alu_b;
    endcase
    // funct3[0] distinguishes BNE from BEQ
    taken = (alu_y == '0) ^ ir[12];
  end

  assign pc_plus4 = pc + A_WIDTH'(4);
  assign br_off   = A_WIDTH'(imm);

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) state <= S_FETCH;
    else     state <= state_n;
  end

  // FSM next state and request strobes.
  always_comb begin
    state_n = state;
    ireq    = 1'b0;
    dreq    = 1'b0;
    case (state)
      S_FETCH: begin
        ireq = 1'b1;
        if (bus.imem_valid) state_n = S_DECODE;
      end
      S_DECODE: state_n = dec_ok ? S_EXEC : S_HALT;
      S_EXEC: begin
        case (cls)
          C_LOAD, C_STORE: state_n = S_MEM;
          C_BRANCH:        state_n = S_FETCH;
          default:         state_n = S_WB;
        endcase
      end
      S_MEM: begin
        dreq = 1'b1;
        if (bus.dmem_valid) state_n = (cls == C_LOAD) ? S_WB : S_FETCH;
      end
      S_WB:    state_n = S_FETCH;
      S_HALT:  state_n = S_HALT;
      default: state_n = S_FETCH;
    endcase
  end

  // Datapath: architectural state is reset; operand/result latches are not,
  // since each is written before it is consumed.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc <= RESET_PC;
      for (int i = 0; i < REG_COUNT; i++) regs[i] <= '0;
    end else begin
      case (state)
        S_FETCH: if (bus.imem_valid) ir <= bus.imem_rdata;
        S_DECODE: begin
          rs1v <= rs1_rd;
          rs2v <= rs2_rd;
          imm  <= dimm;
          cls  <= dcls;
          aop  <= dop;
        end
        S_EXEC: begin
          if (cls == C_BRANCH) pc <= taken ? pc + br_off : pc_plus4;
          else                 res <= alu_y;
        end
        S_MEM: begin
          if (bus.dmem_valid) begin
            if (cls == C_LOAD) res <= bus.dmem_rdata;
            else               pc  <= pc_plus4;
          end
        end
        S_WB: begin
          if (rd != 5'd0) regs[rd[RIW-1:0]] <= res;
          pc <= pc_plus4;
        end
        default: ;
      endcase
    end
  end

  // Outputs are forced low while reset is asserted.
  assign bus.imem_req   = ireq && !rst;
  assign bus.imem_addr  = (ireq && !rst) ? pc : '0;
  assign bus.dmem_req   = dreq && !rst;
  assign bus.dmem_we    = dreq && !rst && (cls == C_STORE);
  assign bus.dmem_addr  = (dreq && !rst) ? A_WIDTH'($unsigned(res)) : '0;
  assign bus.dmem_wdata = (dreq && !rst && cls == C_STORE) ? rs2v : '0;
  assign a0             = rst ? '0 : regs[10];
  assign halted         = !rst && (state == S_HALT);

endmodule

// File: tb/tb_multicycle_cpu.sv
// Directed bench for multicycle_cpu: behavioural memories with programmable
// wait states, a fetch/handshake monitor, and hand-computed expectations.
module tb_multicycle_cpu;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  multicycle_cpu_if #(.A_WIDTH(32), .D_WIDTH(32)) bus ();
  multicycle_cpu_if #(.A_WIDTH(32), .D_WIDTH(32)) bus2 ();
  logic [31:0] a0, a0_2;
  logic        halted, halted2;

  multicycle_cpu #(.D_WIDTH(32), .A_WIDTH(32), .REG_COUNT(32), .RESET_PC(32'h0)) dut (
    .clk(clk), .rst(rst), .bus(bus), .a0(a0), .halted(halted));

  multicycle_cpu #(.D_WIDTH(32), .A_WIDTH(32), .REG_COUNT(16), .RESET_PC(32'h0)) dut16 (
    .clk(clk), .rst(rst), .bus(bus2), .a0(a0_2), .halted(halted2));

  // RV32E-sized core: zero-wait memories, valid permanently high.
  logic [31:0] imem2 [64];
  assign bus2.imem_valid = 1'b1;
  assign bus2.imem_rdata = imem2[bus2.imem_addr[7:2]];
  assign bus2.dmem_valid = 1'b1;
  assign bus2.dmem_rdata = 32'h0;

  logic [31:0] imem [64];
  logic [31:0] dmem [64];
  int          iwait, dwait, icnt, dcnt, cyc, stab_err;
  int          st_cnt, ld_cnt;
  logic [31:0] st_addr, st_data;
  logic        prev_ireq, prev_dreq, prev_dwe;
  logic [31:0] prev_iaddr, prev_daddr, prev_dwdata;
  logic [31:0] rise_addr [$];
  int          rise_cyc [$];
  int          errors = 0;
  int          checks = 0;
  logic [31:0] exp_loop [8] = '{32'h0, 32'h4, 32'h8, 32'h4, 32'h8, 32'h4, 32'h8, 32'hC};

  // Memory models and handshake monitor, evaluated mid-cycle.
  always @(negedge clk) begin
    cyc++;
    if (!rst) begin
      if (prev_ireq && !bus.imem_valid && (!bus.imem_req || bus.imem_addr != prev_iaddr)) stab_err++;
      if (prev_ireq && bus.imem_valid && bus.imem_req) stab_err++;
      if (prev_dreq && !bus.dmem_valid && (!bus.dmem_req || bus.dmem_addr != prev_daddr ||
          bus.dmem_wdata != prev_dwdata || bus.dmem_we != prev_dwe)) stab_err++;
      if (prev_dreq && bus.dmem_valid && bus.dmem_req) stab_err++;
      if (bus.imem_req && !prev_ireq) begin
        rise_addr.push_back(bus.imem_addr);
        rise_cyc.push_back(cyc);
      end
    end
    if (bus.imem_req) begin
      if (icnt >= iwait) begin
        bus.imem_valid = 1'b1;
        bus.imem_rdata = imem[bus.imem_addr[7:2]];
        icnt = 0;
      end else begin
        bus.imem_valid = 1'b0;
        icnt++;
      end
    end else begin
      bus.imem_valid = 1'b0;
      icnt = 0;
    end
    if (bus.dmem_req) begin
      if (dcnt >= dwait) begin
        bus.dmem_valid = 1'b1;
        dcnt = 0;
        if (bus.dmem_we) begin
          dmem[bus.dmem_addr[7:2]] = bus.dmem_wdata;
          st_cnt++;
          st_addr = bus.dmem_addr;
          st_data = bus.dmem_wdata;
        end else begin
          bus.dmem_rdata = dmem[bus.dmem_addr[7:2]];
          ld_cnt++;
        end
      end else begin
        bus.dmem_valid = 1'b0;
        dcnt++;
      end
    end else begin
      bus.dmem_valid = 1'b0;
      dcnt = 0;
    end
    prev_ireq   = bus.imem_req;
    prev_iaddr  = bus.imem_addr;
    prev_dreq   = bus.dmem_req;
    prev_daddr  = bus.dmem_addr;
    prev_dwdata = bus.dmem_wdata;
    prev_dwe    = bus.dmem_we;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic clear_mem();
    foreach (imem[i]) imem[i] = 32'h0;
    foreach (dmem[i]) dmem[i] = 32'h0;
  endtask

  task automatic start_prog();
    @(posedge clk);
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rise_addr.delete();
    rise_cyc.delete();
    stab_err = 0;
    st_cnt   = 0;
    ld_cnt   = 0;
    rst      = 1'b0;
  endtask

  task automatic run_to_halt(input string tag, input int maxc);
    int k;
    k = 0;
    while (!halted && k < maxc) begin
      step();
      k++;
    end
    check({tag, "_halted"}, 64'(halted), 64'd1);
  endtask

  task automatic wait_rises(input string tag, input int n, input int maxc);
    int k;
    k = 0;
    while (rise_addr.size() < n && k < maxc) begin
      step();
      k++;
    end
    check({tag, "_fetch_count"}, 64'(rise_addr.size() >= n), 64'd1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bus.imem_valid = 1'b0; bus.imem_rdata = 32'h0;
    bus.dmem_valid = 1'b0; bus.dmem_rdata = 32'h0;
    iwait = 0; dwait = 0; icnt = 0; dcnt = 0; cyc = 0; stab_err = 0;
    st_cnt = 0; ld_cnt = 0; st_addr = 0; st_data = 0;
    prev_ireq = 0; prev_dreq = 0; prev_dwe = 0;
    prev_iaddr = 0; prev_daddr = 0; prev_dwdata = 0;
    foreach (imem2[i]) imem2[i] = 32'h0;
    imem2[0] = 32'h00500513;   // addi x10,x0,5
    imem2[1] = 32'h00100A13;   // addi x20,x0,1 : illegal index for 16 regs
    imem2[2] = 32'h00900513;   // addi x10,x0,9 : must never execute

    // Single ALU op, zero wait
    clear_mem();
    imem[0] = 32'h00500513;
    start_prog();
    step();
    check("release_req", 64'(bus.imem_req), 64'd1);
    check("release_addr", 64'(bus.imem_addr), 64'h0);
    wait_rises("alu", 2, 20);
    check("alu_a0_at_wb", 64'(a0), 64'd5);
    check("alu_latency", 64'(rise_cyc[1] - rise_cyc[0]), 64'd4);
    check("alu_next_addr", 64'(rise_addr[1]), 64'h4);
    run_to_halt("alu", 20);
    repeat (3) step();
    check("alu_no_req_after_halt", 64'(bus.imem_req), 64'd0);
    check("alu_fetches", 64'(rise_addr.size()), 64'd2);

    // Fetch wait states, then reset while a fetch is pending
    iwait = 3;
    start_prog();
    wait_rises("wait", 2, 40);
    check("wait_latency", 64'(rise_cyc[1] - rise_cyc[0]), 64'd7);
    check("wait_a0", 64'(a0), 64'd5);
    check("wait_stable", 64'(stab_err), 64'd0);
    @(posedge clk);
    #1 rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check($sformatf("rst%0d_req", i), 64'(bus.imem_req), 64'd0);
      check($sformatf("rst%0d_a0", i), 64'(a0), 64'd0);
      check($sformatf("rst%0d_halted", i), 64'(halted), 64'd0);
    end
    @(posedge clk);
    #1;
    rise_addr.delete();
    rise_cyc.delete();
    rst = 1'b0;
    step();
    check("rerelease_req", 64'(bus.imem_req), 64'd1);
    check("rerelease_addr", 64'(bus.imem_addr), 64'h0);
    run_to_halt("wait2", 60);
    check("wait2_a0", 64'(a0), 64'd5);
    check("wait2_stable", 64'(stab_err), 64'd0);

    // Branch loop
    iwait = 0;
    clear_mem();
    imem[0] = 32'h00300593;   // addi x11,x0,3
    imem[1] = 32'h00150513;   // addi x10,x10,1
    imem[2] = 32'hFEB51EE3;   // bne x10,x11,-4
    start_prog();
    run_to_halt("loop", 100);
    check("loop_a0", 64'(a0), 64'd3);
    check("loop_fetches", 64'(rise_addr.size()), 64'd8);
    for (int i = 0; i < 8; i++)
      check($sformatf("loop_fetch%0d", i), 64'(rise_addr[i]), 64'(exp_loop[i]));
    repeat (4) step();
    check("loop_no_req_after_halt", 64'(rise_addr.size()), 64'd8);

    // Store then load, zero wait and with data wait states
    for (int w = 0; w <= 2; w += 2) begin
      dwait = w;
      clear_mem();
      imem[0] = 32'h00500513;   // addi x10,x0,5
      imem[1] = 32'h00A02423;   // sw x10,8(x0)
      imem[2] = 32'h00802603;   // lw x12,8(x0)
      imem[3] = 32'h00C60533;   // add x10,x12,x12
      start_prog();
      run_to_halt($sformatf("ldst%0d", w), 80);
      check($sformatf("ldst%0d_store_cnt", w), 64'(st_cnt), 64'd1);
      check($sformatf("ldst%0d_store_addr", w), 64'(st_addr), 64'h8);
      check($sformatf("ldst%0d_store_data", w), 64'(st_data), 64'd5);
      check($sformatf("ldst%0d_load_cnt", w), 64'(ld_cnt), 64'd1);
      check($sformatf("ldst%0d_mem", w), 64'(dmem[2]), 64'd5);
      check($sformatf("ldst%0d_a0", w), 64'(a0), 64'd10);
      check($sformatf("ldst%0d_st_lat", w), 64'(rise_cyc[2] - rise_cyc[1]), 64'(4 + w));
      check($sformatf("ldst%0d_ld_lat", w), 64'(rise_cyc[3] - rise_cyc[2]), 64'(5 + w));
      check($sformatf("ldst%0d_stable", w), 64'(stab_err), 64'd0);
    end
    dwait = 0;

    // x0 stays zero; branch target wrapping below address 0
    clear_mem();
    imem[0] = 32'h00500513;   // addi x10,x0,5
    imem[1] = 32'h00700013;   // addi x0,x0,7
    imem[2] = 32'h00000533;   // add x10,x0,x0
    imem[3] = 32'hFE0008E3;   // beq x0,x0,-16 -> 0xFFFFFFFC
    start_prog();
    run_to_halt("x0", 60);
    check("x0_a0", 64'(a0), 64'd0);
    check("wrap_fetches", 64'(rise_addr.size()), 64'd5);
    check("wrap_addr", 64'(rise_addr[4]), 64'hFFFF_FFFC);

    // SUB/AND/OR with wraparound, taken BEQ, one fetch wait state
    iwait = 1;
    clear_mem();
    imem[0] = 32'h00100593;   // addi x11,x0,1
    imem[1] = 32'h40B00533;   // sub x10,x0,x11  -> 0xFFFFFFFF
    imem[2] = 32'h07000613;   // addi x12,x0,0x70
    imem[3] = 32'h00C57533;   // and x10,x10,x12 -> 0x70
    imem[4] = 32'h00B56533;   // or x10,x10,x11  -> 0x71
    imem[5] = 32'h00A50463;   // beq x10,x10,+8
    imem[7] = 32'h00A50533;   // add x10,x10,x10 -> 0xE2
    start_prog();
    run_to_halt("ops", 120);
    check("ops_a0", 64'(a0), 64'hE2);
    check("ops_fetches", 64'(rise_addr.size()), 64'd8);
    check("ops_beq_target", 64'(rise_addr[6]), 64'h1C);

    // 16-register core halts on x20 without retiring it
    check("rv32e_halted", 64'(halted2), 64'd1);
    check("rv32e_a0", 64'(a0_2), 64'd5);
    check("rv32e_no_req", 64'(bus2.imem_req), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/multicycle_cpu.md
Name: multicycle_cpu

Overview:
- Parametrised multi-cycle successor to the single-cycle core: one shared ALU, FSM-sequenced fetch/decode/execute/memory/writeback.
- Talks to external instruction and data memories through req/valid handshakes, so it tolerates variable memory wait states.
- Supports the RV32I subset ADD, SUB, AND, OR, ADDI, LW, SW, BEQ, BNE.
- Exposes register x10 on a0 and halts on any unsupported instruction.

Parameters:
- D_WIDTH, 32, register/ALU/data-bus width (>=32); immediates sign-extended to D_WIDTH.
- A_WIDTH, 32, PC and memory address width; all PC arithmetic is modulo 2^A_WIDTH.
- REG_COUNT, 32, architectural registers (32 = RV32I, 16 = RV32E).
- RESET_PC, 0, PC value loaded on reset.

Ports:
- clk  in  1  system clock, rising-edge.
- rst  in  1  synchronous, active-high reset.
- imem_req  out  1  instruction fetch request.
- imem_addr  out  A_WIDTH  fetch byte address (= PC).
- imem_rdata  in  32  fetched instruction.
- imem_valid  in  1  fetch complete; imem_rdata valid this cycle.
- dmem_req  out  1  data access request.
- dmem_we  out  1  1 = store, 0 = load; qualified by dmem_req.
- dmem_addr  out  A_WIDTH  rs1 + imm, truncated to A_WIDTH.
- dmem_wdata  out  D_WIDTH  rs2 value for stores.
- dmem_rdata  in  D_WIDTH  load data.
- dmem_valid  in  1  data access complete.
- a0  out  D_WIDTH  live value of x10.
- halted  out  1  core stopped on an illegal instruction.

Behaviour:

Reset:
- In any cycle with rst=1: PC=RESET_PC, all registers=0, state=FETCH, all outputs 0 (a0=0, halted=0, both req=0).
- Reset mid-transaction abandons the access. A valid arriving without an outstanding req is ignored.
- First imem_req rises in the first cycle after rst falls.

FSM states and transitions:
- FETCH: imem_req=1, imem_addr=PC. Stay until imem_valid=1, then latch IR and go to DECODE.
- DECODE: read rs1/rs2, build the immediate (I/S/B formats), go to EXEC.
  - Unsupported opcode/funct3/funct7 goes to HALT.
  - Any register index >= REG_COUNT goes to HALT.
- EXEC, by instruction class:
  - R-type/ADDI: compute result, go to WB.
  - LW/SW: compute address, go to MEM.
  - BEQ/BNE: PC = taken ? PC+imm : PC+4, go to FETCH.
- MEM: dmem_req=1, dmem_we=store. Address and wdata held stable until dmem_valid=1, then:
  - Load: latch dmem_rdata, go to WB.
  - Store: PC+=4, go to FETCH.
- WB: write rd (x0 writes discarded; x0 always reads 0), PC+=4, go to FETCH.
- HALT: halted=1, no requests, registers frozen. Only rst leaves HALT.

Handshake rules:
- req and its address/data held constant while waiting.
- req drops the cycle after valid is seen.
- No back-to-back req without an intervening FETCH/MEM state entry.

Latency, cycles from req rise to next fetch req, with valid in the same cycle as req:
- ALU/ADDI: 4.
- Branch: 3.
- Store: 4.
- Load: 5.
- Each wait cycle adds 1.

Arithmetic and corner cases:
- ADD/SUB wrap modulo 2^D_WIDTH; no overflow flag.
- No alignment checks; low address bits pass through unchanged.
- A branch target that wraps past the top of the address space wraps silently.

Test Plan:
- Reset: rst held 3 cycles while imem_req pending -> req=0, a0=0 during reset; first imem_req with imem_addr=0 one cycle after release.
- Single ALU op: 0x00500513 (addi x10,x0,5), zero-wait memory -> a0=5 at WB edge; next imem_req at addr 4 exactly 4 cycles after the first req.
- Fetch wait states: imem_valid delayed 3 cycles -> imem_req and imem_addr stable throughout; instruction retires 3 cycles later than in the zero-wait case.
- Branch loop, program:
  - 0x0: 0x00300593 (addi x11,x0,3)
  - 0x4: 0x00150513 (addi x10,x10,1)
  - 0x8: 0xFEB51EE3 (bne x10,x11,-4)
  - 0xC: 0x00000000
  - Required response: fetch sequence 0,4,8,4,8,4,8,C; a0=3; halted=1; no req after the halt.
- Load/store after x10=5:
  - 0x00A02423 (sw x10,8(x0)) -> dmem_we=1, addr=8, wdata=5.
  - 0x00802603 (lw x12,8(x0)) with dmem_rdata=5 -> x12=5, load latency 5 cycles.
- x0 and REG_COUNT: 0x00700013 (addi x0,x0,7) -> x0 still reads 0. With REG_COUNT=16, any instruction using x20 -> halted=1.
